// File: rtl/muffer_window_reader.sv
// Read-side sequencer for the multi-port scratchpad: walks a strided address
// sequence and streams each returned PAR_READ-word window on a valid/ready port.
module muffer_window_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int PAR_READ   = 3,
  parameter int CNT_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr,
  input  logic [CNT_WIDTH-1:0]           count,
  input  logic [ADDR_WIDTH-1:0]          stride,
  output logic                           busy,
  output logic                           done,
  output logic [ADDR_WIDTH-1:0]          mem_read_addr,
  input  logic [PAR_READ*DATA_WIDTH-1:0] mem_read_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PAR_READ*DATA_WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  remaining;
  logic [ADDR_WIDTH-1:0] stride_r;
  logic                  load;
  logic                  leave_run;

  // The output register is free when empty or being drained this cycle.
  always_comb begin
    load      = 1'b0;
    leave_run = 1'b0;
    if (state == RUN) begin
      load      = (remaining != '0) && (!out_valid || out_ready);
      leave_run = (remaining == '0) && (!out_valid || out_ready);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      out_valid     <= 1'b0;
      out_data      <= '0;
      mem_read_addr <= '0;
      remaining     <= '0;
      stride_r      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (count != '0) begin
              state         <= RUN;
              busy          <= 1'b1;
              mem_read_addr <= base_addr;
              remaining     <= count;
              stride_r      <= stride;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (load) begin
            out_data      <= mem_read_data;
            out_valid     <= 1'b1;
            mem_read_addr <= mem_read_addr + stride_r;
            remaining     <= remaining - CNT_WIDTH'(1);
          end
          if (leave_run) begin
            state     <= FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
            out_valid <= 1'b0;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muffer_window_reader.sv
// Bench for muffer_window_reader: scratchpad stub with mem[k]=k+1, queue-based
// transfer model checked every cycle, plus literal latency/window expectations.
module tb_muffer_window_reader;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int PR    = 3;
  localparam int CW    = 8;
  localparam int AW    = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [AW-1:0]     base_addr = '0;
  logic [CW-1:0]     count = '0;
  logic [AW-1:0]     stride = '0;
  logic              busy;
  logic              done;
  logic [AW-1:0]     mem_read_addr;
  logic [PR*DW-1:0]  mem_read_data;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [PR*DW-1:0]  out_data;

  int errors = 0;
  int checks = 0;

  muffer_window_reader #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .PAR_READ(PR), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
    .stride(stride), .busy(busy), .done(done), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word(input int k);
    return DW'((k % DEPTH) + 1);
  endfunction

  // Window starting at address a, wrapping inside the scratchpad.
  function automatic logic [PR*DW-1:0] window(input int a);
    logic [PR*DW-1:0] w;
    w = '0;
    for (int i = 0; i < PR; i++) w[i*DW +: DW] = word(a + i);
    return w;
  endfunction

  always_comb mem_read_data = window(int'(mem_read_addr));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transfer model: pending windows, activity and done expectation.
  logic [PR*DW-1:0] q[$];
  logic [PR*DW-1:0] seen[$];
  bit active = 1'b0;
  bit fresh = 1'b0;
  bit exp_done = 1'b0;
  bit idle;
  int done_count = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      active   = 1'b0;
      fresh    = 1'b0;
      exp_done = 1'b0;
    end else begin
      chk("done", 64'(done), 64'(exp_done));
      chk("busy", 64'(busy), 64'(active));
      chk("out_valid", 64'(out_valid), 64'(active && !fresh && q.size() != 0));
      if (out_valid && q.size() != 0) chk("out_data", 64'(out_data), 64'(q[0]));
      if (done) done_count++;
      idle     = !active && !exp_done;
      exp_done = 1'b0;
      fresh    = 1'b0;
      if (out_valid && out_ready && q.size() != 0) begin
        seen.push_back(out_data);
        void'(q.pop_front());
        if (q.size() == 0) begin
          active   = 1'b0;
          exp_done = 1'b1;
        end
      end
      if (start && idle) begin
        if (count == '0) exp_done = 1'b1;
        else begin
          active = 1'b1;
          fresh  = 1'b1;
          for (int j = 0; j < int'(count); j++)
            q.push_back(window(int'(base_addr) + j * int'(stride)));
        end
      end
    end
  end

  // Issue one command (called just after a rising edge) and wait for done.
  task automatic run(input int b, input int c, input int s, input logic [15:0] pat,
                     input int plen, input int restart_at,
                     output int cycles, output int busy_cycles);
    bit got_done;
    base_addr = AW'(b);
    count     = CW'(c);
    stride    = AW'(s);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    out_ready   = (plen > 0) ? pat[0] : 1'b1;
    cycles      = 0;
    busy_cycles = 0;
    got_done    = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      cycles = k;
      if (busy) busy_cycles++;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      out_ready = (k < plen) ? pat[k] : 1'b1;
      if (k == restart_at) begin
        start     = 1'b1;
        base_addr = AW'(7);
        count     = CW'(2);
        stride    = AW'(5);
      end else start = 1'b0;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("done_within_budget", 64'(got_done), 64'(1));
  endtask

  initial begin
    int cyc, bcyc, n0, d0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_mem_read_addr", 64'(mem_read_addr), 64'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contiguous windows, consumer always ready
    n0 = seen.size();
    run(2, 4, 1, 16'h0, 0, 0, cyc, bcyc);
    chk("t1_done_cycle", 64'(cyc), 64'(6));
    chk("t1_busy_cycles", 64'(bcyc), 64'(5));
    chk("t1_beats", 64'(seen.size() - n0), 64'(4));
    if (seen.size() >= n0 + 4) begin
      chk("t1_first_window", 64'(seen[n0]), 64'h0005_0004_0003);
      chk("t1_last_window", 64'(seen[n0+3]), 64'h0008_0007_0006);
    end
    @(posedge clk);
    #1;

    // Address and window wrap
    n0 = seen.size();
    run(14, 2, 3, 16'h0, 0, 0, cyc, bcyc);
    chk("t2_done_cycle", 64'(cyc), 64'(4));
    chk("t2_beats", 64'(seen.size() - n0), 64'(2));
    if (seen.size() >= n0 + 2) begin
      chk("t2_wrap_window", 64'(seen[n0]), 64'h0001_0010_000F);
      chk("t2_wrap_addr", 64'(seen[n0+1]), 64'h0004_0003_0002);
    end
    @(posedge clk);
    #1;

    // Backpressure 1,0,0,1,0,1
    n0 = seen.size();
    run(0, 3, 2, 16'b10_1001, 6, 0, cyc, bcyc);
    chk("t3_done_cycle", 64'(cyc), 64'(8));
    chk("t3_beats", 64'(seen.size() - n0), 64'(3));
    if (seen.size() >= n0 + 3) begin
      chk("t3_mid_window", 64'(seen[n0+1]), 64'h0005_0004_0003);
      chk("t3_last_window", 64'(seen[n0+2]), 64'h0007_0006_0005);
    end
    @(posedge clk);
    #1;

    // Zero-count command
    n0 = seen.size();
    run(3, 0, 1, 16'h0, 0, 0, cyc, bcyc);
    chk("t4_done_cycle", 64'(cyc), 64'(1));
    chk("t4_busy_cycles", 64'(bcyc), 64'(0));
    chk("t4_beats", 64'(seen.size() - n0), 64'(0));
    @(posedge clk);
    #1;

    // Second start while running is ignored
    n0 = seen.size();
    d0 = done_count;
    run(0, 4, 1, 16'h0, 0, 2, cyc, bcyc);
    chk("t5_done_cycle", 64'(cyc), 64'(6));
    chk("t5_beats", 64'(seen.size() - n0), 64'(4));
    chk("t5_done_pulses", 64'(done_count - d0), 64'(1));
    if (seen.size() >= n0 + 4)
      chk("t5_last_window", 64'(seen[n0+3]), 64'h0006_0005_0004);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_extra_done", 64'(done_count - d0), 64'(1));

    // Reset after the second beat of a count=5 transfer
    base_addr = '0;
    count     = CW'(5);
    stride    = AW'(1);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_valid_before_reset", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_reset_out_valid", 64'(out_valid), 64'(0));
    chk("t6_reset_busy", 64'(busy), 64'(0));
    chk("t6_reset_done", 64'(done), 64'(0));
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    n0 = seen.size();
    run(0, 1, 1, 16'h0, 0, 0, cyc, bcyc);
    chk("t6_done_cycle", 64'(cyc), 64'(3));
    chk("t6_beats", 64'(seen.size() - n0), 64'(1));
    if (seen.size() >= n0 + 1)
      chk("t6_window", 64'(seen[n0]), 64'h0003_0002_0001);

    repeat (3) @(negedge clk);
    #1;
    chk("model_drained", 64'(q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
